// File: rtl/pkt_rr_arbiter_if.sv
// Merge-port bundle for pkt_rr_arbiter: per-queue write side and merged
// output side, each with its own ready.
interface pkt_rr_arbiter_if #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH/8,
   parameter int NUM_QUEUES = 4
);
   logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data;
   logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl;
   logic [NUM_QUEUES-1:0]            in_wr;
   logic [NUM_QUEUES-1:0]            in_rdy;
   logic [DATA_WIDTH-1:0]            out_data;
   logic [CTRL_WIDTH-1:0]            out_ctrl;
   logic                             out_wr;
   logic                             out_rdy;

   modport master (
      output in_data,
      output in_ctrl,
      output in_wr,
      input  in_rdy,
      input  out_data,
      input  out_ctrl,
      input  out_wr,
      output out_rdy
   );

   modport slave (
      input  in_data,
      input  in_ctrl,
      input  in_wr,
      output in_rdy,
      output out_data,
      output out_ctrl,
      output out_wr,
      input  out_rdy
   );
endinterface

// File: rtl/pkt_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_QUEUES NetFPGA streams,
// each buffered in a 4-entry fall-through FIFO.
module pkt_rr_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH/8,
   parameter int NUM_QUEUES = 4,
   parameter int QUEUE_BITS = $clog2(NUM_QUEUES)
) (
   input  logic                  clk,
   input  logic                  reset,
   pkt_rr_arbiter_if.slave       bus,
   output logic [QUEUE_BITS-1:0] cur_queue,
   output logic [31:0]           pkt_count
);

   localparam int W     = CTRL_WIDTH + DATA_WIDTH;
   localparam int DEPTH = 4;
   localparam int QW    = QUEUE_BITS + 1;

   typedef enum logic [1:0] {
      IDLE,
      IN_HDR,
      IN_BODY
   } state_t;

   state_t state;
   state_t state_n;

   logic [W-1:0] mem    [NUM_QUEUES][DEPTH];
   logic [1:0]   wr_ptr [NUM_QUEUES];
   logic [1:0]   rd_ptr [NUM_QUEUES];
   logic [2:0]   count  [NUM_QUEUES];

   logic [NUM_QUEUES-1:0] empty;
   logic [NUM_QUEUES-1:0] nearly_full;
   logic [NUM_QUEUES-1:0] full;
   logic [NUM_QUEUES-1:0] push;
   logic [NUM_QUEUES-1:0] pop;

   logic [QUEUE_BITS-1:0] rr_ptr;
   logic [QUEUE_BITS-1:0] rr_ptr_n;
   logic [QUEUE_BITS-1:0] cur_queue_n;
   logic [QUEUE_BITS-1:0] grant_idx;
   logic [QUEUE_BITS-1:0] cand;
   logic                  found;

   logic [W-1:0] head;
   logic         fwd;
   logic         head_ctrl_zero;
   logic         pkt_done;

   function automatic logic [QUEUE_BITS-1:0] q_add(
      input logic [QUEUE_BITS-1:0] a,
      input int unsigned           k
   );
      logic [QW-1:0] s;
      s = {1'b0, a} + QW'(k);
      if (s >= QW'(NUM_QUEUES))
         s = s - QW'(NUM_QUEUES);
      return s[QUEUE_BITS-1:0];
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
         empty[i]       = (count[i] == 3'd0);
         nearly_full[i] = (count[i] >= 3'd3);
         full[i]        = (count[i] == 3'd4);
      end
   end

   // A write into a full FIFO is dropped rather than corrupting occupancy.
   assign push       = bus.in_wr & ~full;
   assign bus.in_rdy = ~nearly_full;

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
         if (push[i])
            mem[i][wr_ptr[i]] <= {bus.in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH],
                                  bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_QUEUES; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_QUEUES; i++) begin
            if (push[i])
               wr_ptr[i] <= wr_ptr[i] + 2'd1;
            if (pop[i])
               rd_ptr[i] <= rd_ptr[i] + 2'd1;
            case ({push[i], pop[i]})
               2'b10:   count[i] <= count[i] + 3'd1;
               2'b01:   count[i] <= count[i] - 3'd1;
               default: count[i] <= count[i];
            endcase
         end
      end
   end

   assign head           = mem[cur_queue][rd_ptr[cur_queue]];
   assign bus.out_ctrl   = head[W-1 -: CTRL_WIDTH];
   assign bus.out_data   = head[DATA_WIDTH-1:0];
   assign head_ctrl_zero = (bus.out_ctrl == '0);

   // Gated by reset so a mid-packet reset silences the output at once.
   assign fwd = (state != IDLE) && !empty[cur_queue]
             && bus.out_rdy && !reset;
   assign bus.out_wr = fwd;

   always_comb begin
      for (int i = 0; i < NUM_QUEUES; i++)
         pop[i] = fwd && (cur_queue == QUEUE_BITS'(i));
   end

   always_comb begin
      found     = 1'b0;
      grant_idx = rr_ptr;
      cand      = '0;
      for (int k = 0; k < NUM_QUEUES; k++) begin
         cand = q_add(rr_ptr, k);
         if (!found && !empty[cand]) begin
            found     = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_comb begin
      state_n     = state;
      cur_queue_n = cur_queue;
      rr_ptr_n    = rr_ptr;
      pkt_done    = 1'b0;
      unique case (state)
         IDLE: begin
            if (found) begin
               cur_queue_n = grant_idx;
               state_n     = IN_HDR;
            end
         end
         IN_HDR: begin
            if (fwd && head_ctrl_zero)
               state_n = IN_BODY;
         end
         IN_BODY: begin
            if (fwd && !head_ctrl_zero) begin
               state_n  = IDLE;
               rr_ptr_n = q_add(cur_queue, 1);
               pkt_done = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         cur_queue <= '0;
         pkt_count <= '0;
      end else begin
         state     <= state_n;
         rr_ptr    <= rr_ptr_n;
         cur_queue <= cur_queue_n;
         if (pkt_done)
            pkt_count <= pkt_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Scoreboard bench for pkt_rr_arbiter: per-queue sources, expected
// words queued at stimulus time, compared as out_wr words appear.
module tb_pkt_rr_arbiter;

   localparam int DW = 64;
   localparam int CW = 8;
   localparam int NQ = 4;
   localparam int QB = 2;

   typedef logic [CW+DW-1:0] word_t;
   typedef struct packed {
      logic [QB-1:0] q;
      word_t         w;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [QB-1:0] cur_queue;
   logic [31:0]   pkt_count;

   pkt_rr_arbiter_if #(.DATA_WIDTH(DW), .NUM_QUEUES(NQ)) bus();

   pkt_rr_arbiter #(.DATA_WIDTH(DW), .NUM_QUEUES(NQ)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .cur_queue (cur_queue),
      .pkt_count (pkt_count)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   int    t_drv = -1;
   int    pid = 0;
   int    wid = 0;
   word_t last_w;
   word_t src [NQ][$];
   exp_t  exp_q[$];
   exp_t  hold[$];
   exp_t  mon_e;
   int    out_cyc[$];

   task automatic chk(input string tag, input logic [71:0] got,
                      input logic [71:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   initial begin : driver
      word_t w;
      bus.in_wr   = '0;
      bus.in_data = '0;
      bus.in_ctrl = '0;
      forever begin
         @(posedge clk); #1;
         for (int q = 0; q < NQ; q++) begin
            bus.in_wr[q] = 1'b0;
            if (!reset && src[q].size() > 0 && bus.in_rdy[q]) begin
               w = src[q].pop_front();
               bus.in_ctrl[q*CW +: CW] = w[71:64];
               bus.in_data[q*DW +: DW] = w[63:0];
               bus.in_wr[q] = 1'b1;
               if (t_drv < 0)
                  t_drv = cyc;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (bus.out_wr) begin
         out_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            chk("spurious_out_wr", exp_q.size(), 1);
         end else begin
            mon_e = exp_q.pop_front();
            chk("word", {bus.out_ctrl, bus.out_data}, mon_e.w);
            chk("grant_q", cur_queue, mon_e.q);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic put(input int q, input logic [7:0] c, input bit expect_it);
      word_t w;
      w = {c, 16'hA5A5, 8'(q), 8'(pid), 16'h0, 16'(wid)};
      wid++;
      last_w = w;
      src[q].push_back(w);
      if (expect_it)
         exp_q.push_back('{q: QB'(q), w: w});
   endtask

   task automatic send_pkt(input int q, input int nhdr, input int nbody);
      for (int i = 0; i < nhdr; i++) put(q, 8'hFF, 1'b1);
      for (int i = 0; i < nbody; i++) put(q, 8'h00, 1'b1);
      put(q, 8'h80, 1'b1);
      pid++;
   endtask

   function automatic bit src_busy();
      for (int q = 0; q < NQ; q++)
         if (src[q].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drain(input int budget);
      int i;
      i = 0;
      while ((exp_q.size() != 0 || src_busy()) && i < budget) begin
         tick(1);
         i++;
      end
      chk("drain_timeout", exp_q.size(), 0);
      tick(3);
   endtask

   task automatic wait_words(input int n, input int budget);
      int i;
      i = 0;
      while (out_cyc.size() < n && i < budget) begin
         tick(1);
         i++;
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      tick(n);
      reset = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin : main
      bus.out_rdy = 1'b1;
      tick(3);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_in_rdy", bus.in_rdy, 4'hF);
      chk("rst_out_wr", bus.out_wr, 1'b0);
      chk("rst_cur_queue", cur_queue, 0);
      chk("rst_pkt_count", pkt_count, 0);
      tick(1);

      // single packet on queue 2
      out_cyc.delete();
      t_drv = -1;
      send_pkt(2, 1, 3);
      drain(60);
      chk("single_nwords", out_cyc.size(), 5);
      if (out_cyc.size() == 5) begin
         chk("single_latency", out_cyc[0] - t_drv, 2);
         chk("single_contig", out_cyc[4] - out_cyc[0], 4);
      end
      chk("single_cur_queue", cur_queue, 2);
      chk("single_pkt_count", pkt_count, 1);

      // contention across all four queues, then a reload round
      do_reset(1);
      out_cyc.delete();
      for (int q = 0; q < NQ; q++) send_pkt(q, 1, 1);
      drain(100);
      chk("cont_nwords", out_cyc.size(), 12);
      if (out_cyc.size() == 12) begin
         for (int p = 0; p < NQ; p++) begin
            chk("cont_contig", out_cyc[3*p+2] - out_cyc[3*p], 2);
            if (p > 0)
               chk("cont_gap", out_cyc[3*p] - out_cyc[3*p-1], 2);
         end
      end
      chk("cont_pkt_count", pkt_count, 4);
      out_cyc.delete();
      send_pkt(0, 1, 1);
      send_pkt(1, 1, 1);
      drain(60);
      chk("reload_nwords", out_cyc.size(), 6);
      chk("reload_pkt_count", pkt_count, 6);

      // backpressure mid-body on queue 1
      out_cyc.delete();
      send_pkt(1, 1, 8);
      wait_words(3, 50);
      chk("bp_reach", out_cyc.size(), 3);
      bus.out_rdy = 1'b0;
      tick(5);
      chk("bp_silent", out_cyc.size(), 3);
      chk("bp_in_rdy", bus.in_rdy[1], 1'b0);
      bus.out_rdy = 1'b1;
      drain(100);
      chk("bp_nwords", out_cyc.size(), 10);
      chk("bp_pkt_count", pkt_count, 7);

      // queue 1 starves mid-body while queue 3 waits with a full packet
      out_cyc.delete();
      hold.delete();
      put(1, 8'hFF, 1'b1);
      put(1, 8'h00, 1'b1);
      put(1, 8'h00, 1'b1);
      tick(8);
      put(3, 8'hFF, 1'b0); hold.push_back('{q: 2'd3, w: last_w});
      put(3, 8'h00, 1'b0); hold.push_back('{q: 2'd3, w: last_w});
      put(3, 8'h80, 1'b0); hold.push_back('{q: 2'd3, w: last_w});
      tick(10);
      chk("starve_cur_queue", cur_queue, 1);
      chk("starve_nwords", out_cyc.size(), 3);
      put(1, 8'h00, 1'b1);
      put(1, 8'h80, 1'b1);
      pid++;
      foreach (hold[i]) exp_q.push_back(hold[i]);
      drain(80);
      chk("starve_total", out_cyc.size(), 8);
      chk("starve_pkt_count", pkt_count, 9);

      // reset after two of six words from queue 1
      out_cyc.delete();
      for (int i = 0; i < 6; i++)
         put(1, (i == 0) ? 8'hFF : ((i == 5) ? 8'h80 : 8'h00), i < 2);
      pid++;
      wait_words(2, 50);
      chk("rst_mid_reach", out_cyc.size(), 2);
      reset = 1'b1;
      src[1].delete();
      tick(1);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_in_rdy", bus.in_rdy, 4'hF);
      chk("rst_mid_out_wr", bus.out_wr, 1'b0);
      tick(5);
      chk("rst_mid_silent", out_cyc.size(), 2);
      send_pkt(3, 1, 2);
      drain(60);
      chk("rst_mid_nwords", out_cyc.size(), 6);
      chk("rst_mid_pkt_count", pkt_count, 1);
      chk("rst_mid_cur_queue", cur_queue, 3);

      // pkt_count wrap
      force dut.pkt_count = 32'hFFFF_FFFF;
      tick(1);
      release dut.pkt_count;
      tick(1);
      chk("wrap_pre", pkt_count, 32'hFFFF_FFFF);
      send_pkt(0, 1, 1);
      drain(60);
      chk("wrap_pkt_count", pkt_count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
